// File: rtl/dma_write_fifo_pkg.sv
// Shared types and constants for the DMA write-command path.
package dma_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // One CPU write command: address in the upper half, data in the lower half.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dma_entry_t;

  localparam int unsigned ENTRY_W = $bits(dma_entry_t);

  // Status LED bit positions.
  localparam int unsigned LED_W         = 12;
  localparam int unsigned LED_OCC_W     = 8;
  localparam int unsigned LED_FULL      = 8;
  localparam int unsigned LED_EMPTY     = 9;
  localparam int unsigned LED_PHASE     = 10;
  localparam int unsigned LED_UNDERFLOW = 11;

  // Stream pairing phase: next accepted word is an address or a data word.
  typedef enum logic {
    PH_ADDR = 1'b0,
    PH_DATA = 1'b1
  } phase_e;

endpackage

// File: rtl/dma_write_fifo_if.sv
// Stream-in / command-out bundle of the DMA write FIFO.
interface dma_write_fifo_if;
  import dma_pkg::*;

  logic [DATA_W-1:0]  s_tdata;
  logic [3:0]         s_tkeep;
  logic               s_tlast;
  logic               s_tvalid;
  logic               s_tready;
  logic               dma_re;
  logic [ENTRY_W-1:0] dma_out;
  logic               dma_r_enable;
  logic [LED_W-1:0]   led;

  // Producer of the stream and consumer of the commands.
  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid, dma_re,
    input  s_tready, dma_out, dma_r_enable, led
  );

  // The FIFO block itself.
  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid, dma_re,
    output s_tready, dma_out, dma_r_enable, led
  );

endinterface

// File: rtl/dma_write_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy counter and a registered read port.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr;
  logic             rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr    = wr_en && !full  && !clr;
  assign rd    = rd_en && !empty && !clr;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; clear has priority over push and pop.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered head read; holds its value when no pop happens.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)  rd_data <= '0;
    else if (rd)  rd_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/dma_write_fifo.sv
// Pairs address/data stream words into write commands, buffers them and
// hands them to the CPU write port one per pop.
module dma_write_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             fifo_reset,
  dma_write_fifo_if.slave  bus
);

  phase_e             ph;
  phase_e             ph_next;
  logic [ADDR_W-1:0]  addr_hold;
  logic               addr_load;
  logic               push;
  logic               s_ready;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               r_enable;
  logic               underflow;
  logic [LED_W-1:0]   led;
  dma_entry_t         wr_entry;
  logic [ENTRY_W-1:0] rd_data;
  logic               unused_tkeep;

  assign unused_tkeep = ^bus.s_tkeep;

  // Pairing phase register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ph <= PH_ADDR;
    else         ph <= ph_next;
  end

  // Handshake and pairing decisions; tlast always returns to the address phase.
  always_comb begin
    ph_next   = ph;
    addr_load = 1'b0;
    push      = 1'b0;
    s_ready   = !(((ph == PH_DATA) && full) || fifo_reset);
    if (fifo_reset) begin
      ph_next = PH_ADDR;
    end else if (bus.s_tvalid && s_ready) begin
      case (ph)
        PH_ADDR: begin
          addr_load = 1'b1;
          ph_next   = bus.s_tlast ? PH_ADDR : PH_DATA;
        end
        PH_DATA: begin
          push    = 1'b1;
          ph_next = PH_ADDR;
        end
        default: ph_next = PH_ADDR;
      endcase
    end
  end

  // Address holding register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)         addr_hold <= '0;
    else if (fifo_reset) addr_hold <= '0;
    else if (addr_load)  addr_hold <= bus.s_tdata;
  end

  assign wr_entry = '{addr: addr_hold, data: bus.s_tdata};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .clr     (fifo_reset),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (bus.dma_re),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Pop strobe follows a successful pop by one cycle; sticky underflow flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_enable  <= 1'b0;
      underflow <= 1'b0;
    end else if (fifo_reset) begin
      r_enable  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      r_enable <= bus.dma_re && !empty;
      if (bus.dma_re && empty) underflow <= 1'b1;
    end
  end

  // Status bits straight from registered state.
  always_comb begin
    led                  = '0;
    led[LED_OCC_W-1:0]   = LED_OCC_W'(count);
    led[LED_FULL]        = full;
    led[LED_EMPTY]       = empty;
    led[LED_PHASE]       = (ph == PH_DATA);
    led[LED_UNDERFLOW]   = underflow;
  end

  assign bus.s_tready     = s_ready;
  assign bus.dma_out      = rd_data;
  assign bus.dma_r_enable = r_enable;
  assign bus.led          = led;

endmodule

// File: tb/tb_dma_write_fifo.sv
// Directed bench for dma_write_fifo.
module tb_dma_write_fifo;

  logic clk;
  logic nreset;
  logic fifo_reset;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [63:0] exp_q[$];
  logic [63:0] want;
  int unsigned w;
  int unsigned total_wait;

  dma_write_fifo_if bus ();

  dma_write_fifo #(.DEPTH(64)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .fifo_reset (fifo_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present one beat and hold it until accepted (bounded); reports stall cycles.
  task automatic send_beat(input logic [31:0] d, input logic last, output int unsigned waited);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = d;
    bus.s_tlast  = last;
    waited = 0;
    @(negedge clk);
    while (!bus.s_tready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  // Hold dma_re for n cycles and compare each strobe/entry against the model.
  task automatic drain(input int unsigned n, input string tag);
    logic [63:0] e;
    bus.dma_re = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == n - 1) bus.dma_re = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      check({tag, "_strobe"}, 64'(bus.dma_r_enable), 64'd1);
      check({tag, "_data"}, bus.dma_out, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nreset = 1'b0;
    fifo_reset = 1'b1;
    bus.s_tdata = '0;
    bus.s_tkeep = '0;
    bus.s_tlast = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.dma_re = 1'b0;

    // Reset
    #50;
    check("reset_tready_low", 64'(bus.s_tready), 64'd0);
    check("reset_dma_out", bus.dma_out, 64'd0);
    check("reset_strobe", 64'(bus.dma_r_enable), 64'd0);
    check("reset_led", 64'(bus.led), 64'h200);
    #51;
    nreset = 1'b1;
    fifo_reset = 1'b0;
    @(negedge clk);
    check("post_reset_tready", 64'(bus.s_tready), 64'd1);
    check("post_reset_led", 64'(bus.led), 64'h200);
    @(posedge clk); #1;

    // Fill: 32 pairs at 0x8000_0000+i, then 32 pairs at 0x2000_0000+4i
    total_wait = 0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] a, d;
      a = (i < 32) ? 32'h8000_0000 + 32'(i) : 32'h2000_0000 + 32'(4 * (i - 32));
      d = 32'hDEAD_BEAF + 32'(i % 32);
      send_beat(a, 1'b0, w); total_wait += w;
      send_beat(d, 1'b0, w); total_wait += w;
      exp_q.push_back({a, d});
    end
    @(negedge clk);
    check("fill_no_stall", 64'(total_wait), 64'd0);
    check("fill_occupancy", 64'(bus.led[7:0]), 64'd64);
    check("fill_full", 64'(bus.led[8]), 64'd1);
    check("fill_not_empty", 64'(bus.led[9]), 64'd0);
    check("fill_phase", 64'(bus.led[10]), 64'd0);
    check("fill_tready_addr", 64'(bus.s_tready), 64'd1);
    @(posedge clk); #1;

    // Drain 64 back-to-back
    drain(64, "drain");
    @(posedge clk); #1;
    check("drain_strobe_off", 64'(bus.dma_r_enable), 64'd0);
    check("drain_end_led", 64'(bus.led), 64'h200);

    // Full stall
    total_wait = 0;
    for (int i = 0; i < 64; i++) begin
      send_beat(32'h1000 + 32'(i), 1'b0, w); total_wait += w;
      send_beat(32'h0F00 + 32'(i), 1'b0, w); total_wait += w;
      exp_q.push_back({32'h1000 + 32'(i), 32'h0F00 + 32'(i)});
    end
    check("refill_no_stall", 64'(total_wait), 64'd0);
    send_beat(32'h5555, 1'b0, w);
    check("stall_addr_accepted", 64'(w), 64'd0);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 32'h6666;
    @(negedge clk);
    check("stall_tready_low", 64'(bus.s_tready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_tready_still_low", 64'(bus.s_tready), 64'd0);
    check("stall_occupancy", 64'(bus.led[7:0]), 64'd64);
    check("stall_phase", 64'(bus.led[10]), 64'd1);
    @(posedge clk); #1;
    bus.dma_re = 1'b1;
    @(posedge clk); #1;
    bus.dma_re = 1'b0;
    want = exp_q.pop_front();
    check("stall_pop_strobe", 64'(bus.dma_r_enable), 64'd1);
    check("stall_pop_data", bus.dma_out, want);
    @(negedge clk);
    check("stall_tready_after_pop", 64'(bus.s_tready), 64'd1);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    exp_q.push_back({32'h5555, 32'h6666});
    check("stall_refull", 64'(bus.led[7:0]), 64'd64);
    check("stall_phase_done", 64'(bus.led[10]), 64'd0);
    check("stall_strobe_one_cycle", 64'(bus.dma_r_enable), 64'd0);
    drain(64, "stall_drain");
    @(posedge clk); #1;

    // Underflow and clear
    bus.dma_re = 1'b1;
    @(posedge clk); #1;
    bus.dma_re = 1'b0;
    check("uflow_no_strobe", 64'(bus.dma_r_enable), 64'd0);
    check("uflow_flag", 64'(bus.led[11]), 64'd1);
    check("uflow_dma_out_held", bus.dma_out, {32'h5555, 32'h6666});
    @(posedge clk); #1;
    check("uflow_sticky", 64'(bus.led[11]), 64'd1);
    fifo_reset = 1'b1;
    @(negedge clk);
    check("clr_tready_low", 64'(bus.s_tready), 64'd0);
    @(posedge clk); #1;
    fifo_reset = 1'b0;
    check("clr_led", 64'(bus.led), 64'h200);

    // tlast realign
    send_beat(32'hA, 1'b1, w);
    send_beat(32'hB, 1'b0, w);
    send_beat(32'hC, 1'b0, w);
    exp_q.push_back({32'hB, 32'hC});
    @(negedge clk);
    check("tlast_one_entry", 64'(bus.led[7:0]), 64'd1);
    check("tlast_phase", 64'(bus.led[10]), 64'd0);
    @(posedge clk); #1;
    drain(1, "tlast");
    @(posedge clk); #1;
    check("tlast_end_led", 64'(bus.led), 64'h200);

    // nreset mid-transfer drops entries and the partial pair
    send_beat(32'h11, 1'b0, w);
    send_beat(32'h22, 1'b0, w);
    send_beat(32'h33, 1'b0, w);
    #2;
    nreset = 1'b0;
    #1;
    check("nrst_led", 64'(bus.led), 64'h200);
    check("nrst_dma_out", bus.dma_out, 64'd0);
    check("nrst_tready", 64'(bus.s_tready), 64'd1);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    send_beat(32'h44, 1'b0, w);
    send_beat(32'h55, 1'b0, w);
    exp_q.push_back({32'h44, 32'h55});
    drain(1, "nrst_pair");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_write_fifo.md
# dma_write_fifo

Receives a 32-bit AXI-Stream of alternating address/data words and pairs them into 64-bit write commands `{addr, data}`. Buffers the commands in a synchronous FIFO. Presents them one per pop to the CPU write port (`cpu_write_addr_in`, `cpu_write_data_in`, `cpu_write_enable_in` of `cpu_top`). It sits between the PL DMA engine and the CPU restore/register-load logic.

## Interface
Parameters:
- `DEPTH`, default 64: FIFO entries; must be a power of two.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy counter.

Ports:
- `clk`, in, 1: the single clock. Rising edge is active.
- `nreset`, in, 1: reset, asynchronous and active-low.
- `fifo_reset`, in, 1: synchronous clear, active-high.
- `s_tdata`, in, 32: stream word.
- `s_tkeep`, in, 4: ignored.
- `s_tlast`, in, 1: end of packet; realigns pairing.
- `s_tvalid`, in, 1: stream valid.
- `s_tready`, out, 1: stream ready.
- `dma_re`, in, 1: pop request.
- `dma_out`, out, 64: popped entry; `[63:32]` is the address, `[31:0]` is the data.
- `dma_r_enable`, out, 1: one-cycle strobe; `dma_out` is valid while it is high.
- `led`, out, 12: status bits.
  - `[7:0]` occupancy, zero-extended.
  - `[8]` full.
  - `[9]` empty.
  - `[10]` pairing phase.
  - `[11]` sticky underflow.

## Operation
- A beat is accepted when `s_tvalid && s_tready`.
- Pairing phase bit `ph`:
  - When `ph=0`, the accepted word is latched into the address holding register and `ph` becomes 1.
  - When `ph=1`, the word is data. `{addr_hold, s_tdata}` is pushed into the FIFO and `ph` becomes 0.
- `s_tlast` on an accepted beat forces `ph` to 0 afterwards. On an address beat, that address is discarded with no push.
- `s_tready` is the negation of `(ph && full) || fifo_reset`.
  - Address beats are always accepted outside `fifo_reset`.
  - A data beat stalls while the FIFO is full.
- Pop:
  - `dma_re && !empty` reads the head, advances the read pointer, and registers the entry into `dma_out`.
  - `dma_r_enable` is high for exactly the next cycle.
  - When `dma_re` is held with data available, the block delivers one entry per cycle, back-to-back.
- Underflow: `dma_re && empty` sets `led[11]`, leaves `dma_out` unchanged, and keeps `dma_r_enable` low. The bit is cleared by `fifo_reset` or `nreset`.
- `fifo_reset` clears the following and has priority over push and pop in the same cycle:
  - pointers, occupancy and `ph`
  - the address holding register
  - `dma_r_enable` and `led[11]`
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - If empty, only the push takes effect; there is no bypass, so the data is visible to a pop on the next cycle.
  - If full, the pop proceeds, and the data beat stays stalled this cycle because `s_tready` is computed from the pre-pop state.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy ranges 0..DEPTH. Full means occupancy equals DEPTH; empty means occupancy is 0.

## Timing
- Reset values (`nreset` low):
  - `dma_out=0`, `dma_r_enable=0`, `ph=0`, occupancy 0.
  - `s_tready=1`, `led=12'h200` (empty bit set).
- Push to visible: a pushed entry can be popped starting the cycle after the data beat.
- Pop latency: `dma_re` sampled at edge N gives `dma_out`/`dma_r_enable` valid after edge N, for one cycle.
- `led` is combinational from the registered state.
- `nreset` asserted mid-transfer drops the partial pair and all entries immediately. The block is in the empty state on the first edge after release.

## Structure
- Shared package `dma_pkg`:
  - `ADDR_W=32`, `DATA_W=32`.
  - typedef `dma_entry_t` as the packed struct `{addr, data}` (64 bits).
  - `led` bit-index constants.
- One sub-module `sync_fifo`, parameterised by width and `DEPTH`:
  - inputs: write enable, read enable, synchronous clear
  - outputs: `full`, `empty`, `count`, and a registered read data port
- The top level holds the pairing FSM (`ph` plus the address register), the `s_tready` logic, the pop strobe and the status bits.

## Test plan
- **Reset:** hold `nreset=0` and `fifo_reset=1` for 100 ns. Require `s_tready=0` during `fifo_reset`, and `s_tready=1` with `led=12'h200` after release.
- **Fill:**
  - Stream 32 pairs (`0x80000000+i`, `0xDEADBEAF+i`) and then 32 pairs (`0x20000000+4i`, `0xDEADBEAF+i`), with `s_tvalid` held high and `s_tkeep=0`.
  - Require all beats accepted, occupancy 64, `led[8]=1`, `ph=0`.
- **Drain:**
  - Hold `dma_re` for 64 cycles.
  - Require 64 consecutive `dma_r_enable` strobes with `dma_out = {0x80000000+i, 0xDEADBEAF+i}` for i=0..31, then `{0x20000000+4i, 0xDEADBEAF+i}`.
  - Require the block to end empty with `led[11]=0`.
- **Full stall:** with the FIFO full, send an address beat and then a data beat. Require the address beat accepted, the data beat held by `s_tready=0`, and the data beat accepted the cycle after a single pop.
- **Underflow and clear:** pulse `dma_re` while empty. Require no strobe and `led[11]=1`; then pulse `fifo_reset` and require `led[11]=0`.
- **tlast realign:** send address `0xA` with `s_tlast=1`, then `0xB`, then `0xC`. Require exactly one entry `{0xB, 0xC}`.
